// File: rtl/selector_pkg.sv
// selector_pkg
// Shared definitions for the selector_scan block: mode encodings and a
// ceil-log2 helper used to validate the select-width parameter and to
// size the dwell counter.
package selector_pkg;

    // iMode encodings
    localparam logic MODE_MANUAL = 1'b0;
    localparam logic MODE_AUTO   = 1'b1;

    // Smallest n such that 2**n >= value (returns 0 for value <= 1).
    function automatic int unsigned ceilLog2(input int unsigned value);
        int unsigned result;
        int unsigned span;
        result = 32'd0;
        span   = 32'd1;
        while (span < value) begin
            span   = span << 1;
            result = result + 32'd1;
        end
        return result;
    endfunction

endpackage

// File: rtl/selector_scan_timer.sv
// scan_timer
// Dwell counter for auto-scan. Counts 0..DWELL-1 while enabled and not held,
// wrapping to 0 at the terminal count and flagging that cycle with oTick.
// Ports:
//   iCLK    clock, rising edge
//   iRST    synchronous active-high reset (counter -> 0)
//   iClear  synchronous clear (counter -> 0), dominates iHold
//   iEnable count enable (auto-scan active)
//   iHold   freezes the counter; suppresses oTick
//   oTick   high in the cycle whose edge ends a dwell period
module scan_timer
    import selector_pkg::*;
#(
    parameter int DWELL = 4
) (
    input  logic iCLK,
    input  logic iRST,
    input  logic iClear,
    input  logic iEnable,
    input  logic iHold,
    output logic oTick
);

    localparam int              CNT_W    = (DWELL > 1) ? int'(ceilLog2(DWELL)) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DWELL - 1);

    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cntNext_s;

    // Next-count and terminal-tick decode.
    always_comb begin
        cntNext_s = cnt_r;
        oTick     = 1'b0;
        if (iClear) begin
            cntNext_s = '0;
        end else if (iHold) begin
            cntNext_s = cnt_r;
        end else if (iEnable) begin
            if (cnt_r == LAST_CNT) begin
                cntNext_s = '0;
                oTick     = 1'b1;
            end else begin
                cntNext_s = cnt_r + CNT_W'(1'b1);
            end
        end else begin
            cntNext_s = cnt_r;
        end
    end

    // Dwell counter register.
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            cnt_r <= '0;
        end else begin
            cnt_r <= cntNext_s;
        end
    end

endmodule

// File: rtl/selector_scan.sv
// selector_scan
// Registered N-channel, W-bit selector with manual select and round-robin
// auto-scan. The channel register and the outputs update on the same edge,
// so oZ always shows the slice of the channel that oCh names.
// Ports:
//   iCLK   clock, rising edge
//   iRST   synchronous active-high reset
//   iData  flattened channels, channel k at [k*WIDTH +: WIDTH]
//   iSel   manual channel select (ignored in auto mode)
//   iMode  0 = manual, 1 = auto-scan
//   iHold  freezes channel and dwell counter; oZ keeps tracking live data
//   oZ     registered selected data
//   oCh    registered channel index driving oZ
//   oStep  one-cycle pulse on each auto-scan advance
//   oErr   registered; high while a manual iSel is out of range
module selector_scan
    import selector_pkg::*;
#(
    parameter int WIDTH    = 4,
    parameter int CHANNELS = 4,
    parameter int SEL_W    = 2,
    parameter int DWELL    = 4
) (
    input  logic                      iCLK,
    input  logic                      iRST,
    input  logic [CHANNELS*WIDTH-1:0] iData,
    input  logic [SEL_W-1:0]          iSel,
    input  logic                      iMode,
    input  logic                      iHold,
    output logic [WIDTH-1:0]          oZ,
    output logic [SEL_W-1:0]          oCh,
    output logic                      oStep,
    output logic                      oErr
);

    // Elaboration-time parameter sanity.
    if (CHANNELS < 2 || CHANNELS > 16) begin : gBadChannels
        $error("selector_scan: CHANNELS must be in 2..16");
    end
    if (SEL_W < int'(ceilLog2(CHANNELS))) begin : gBadSelW
        $error("selector_scan: SEL_W too narrow for CHANNELS");
    end
    if (DWELL < 1) begin : gBadDwell
        $error("selector_scan: DWELL must be >= 1");
    end

    localparam logic [SEL_W-1:0] LAST_CH = SEL_W'(CHANNELS - 1);

    logic [SEL_W-1:0] ch_r;
    logic [SEL_W-1:0] chNext_s;
    logic [WIDTH-1:0] selData_s;
    logic             selInvalid_s;
    logic             errNext_s;
    logic             stepNext_s;
    logic             tick_s;
    logic             timerClear_s;

    // The counter is parked at 0 whenever manual mode is active and not held,
    // so a later switch to auto gets a full first dwell period.
    assign timerClear_s = ~iHold & (iMode == MODE_MANUAL);
    assign selInvalid_s = (32'(iSel) >= CHANNELS);

    scan_timer #(
        .DWELL (DWELL)
    ) uTimer (
        .iCLK    (iCLK),
        .iRST    (iRST),
        .iClear  (timerClear_s),
        .iEnable (iMode == MODE_AUTO),
        .iHold   (iHold),
        .oTick   (tick_s)
    );

    // Next channel, error and step decode; hold dominates both modes.
    always_comb begin
        chNext_s   = ch_r;
        errNext_s  = 1'b0;
        stepNext_s = 1'b0;
        if (iHold) begin
            chNext_s  = ch_r;
            errNext_s = (iMode == MODE_MANUAL) & selInvalid_s;
        end else if (iMode == MODE_MANUAL) begin
            if (selInvalid_s) begin
                chNext_s  = ch_r;
                errNext_s = 1'b1;
            end else begin
                chNext_s  = iSel;
                errNext_s = 1'b0;
            end
        end else begin
            if (tick_s) begin
                // Explicit wrap so non-power-of-2 channel counts never
                // visit unused indices.
                chNext_s   = (ch_r == LAST_CH) ? '0 : ch_r + SEL_W'(1'b1);
                stepNext_s = 1'b1;
            end else begin
                chNext_s   = ch_r;
                stepNext_s = 1'b0;
            end
        end
    end

    // Data mux on the post-edge channel so oZ and oCh stay aligned.
    always_comb begin
        selData_s = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            if (chNext_s == SEL_W'(k)) begin
                selData_s = iData[k*WIDTH +: WIDTH];
            end else begin
                selData_s = selData_s;
            end
        end
    end

    // Channel register and registered outputs.
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            ch_r  <= '0;
            oZ    <= '0;
            oCh   <= '0;
            oStep <= 1'b0;
            oErr  <= 1'b0;
        end else begin
            ch_r  <= chNext_s;
            oZ    <= selData_s;
            oCh   <= chNext_s;
            oStep <= stepNext_s;
            oErr  <= errNext_s;
        end
    end

endmodule

// File: doc/selector_scan.md
Name: selector_scan

Overview:
- Parametrised, registered N-channel, W-bit selector; the next generation of the team's 4-to-1 selector.
- Two modes: manual, where the select input picks the channel, and auto-scan, where the channel advances round-robin after a programmable dwell time.
- Used to time-multiplex lab data sources (switch banks, counters) onto a single display or LED bus.
- Output is registered, with a channel index and an advance pulse for downstream display logic.

Parameters:
- WIDTH, 4, bits per channel.
- CHANNELS, 4, number of input channels (2..16).
- SEL_W, 2, width of select/channel index; must satisfy 2**SEL_W >= CHANNELS.
- DWELL, 4, clock cycles each channel is held in auto-scan (>= 1).

Ports:
- iCLK  input  1  clock; all state updates on the rising edge.
- iRST  input  1  synchronous, active-high reset.
- iData  input  CHANNELS*WIDTH  flattened channels; channel k occupies bits [k*WIDTH +: WIDTH].
- iSel  input  SEL_W  manual channel select.
- iMode  input  1  0 = manual, 1 = auto-scan.
- iHold  input  1  freezes channel index and dwell counter; oZ keeps tracking live data of the held channel.
- oZ  output  WIDTH  registered selected data.
- oCh  output  SEL_W  registered index of the channel currently driving oZ.
- oStep  output  1  one-cycle pulse, coincident with oCh changing in auto mode.
- oErr  output  1  registered; high while manual iSel >= CHANNELS.

Behaviour:
- Reset (iRST=1 at an edge):
  - ch=0, dwell counter=0.
  - oZ=0, oCh=0, oStep=0, oErr=0.
  - Reset overrides every other input, including mid-scan or mid-hold.
- Latency:
  - oZ at edge t = iData slice of the channel register value after edge t.
  - Effectively one cycle from iSel/iData change to oZ.
- Manual mode (iMode=0):
  - Valid select (iSel < CHANNELS): ch <= iSel.
  - Invalid select (iSel >= CHANNELS): ch is held and oErr <= 1.
  - Dwell counter is held at 0; oStep=0.
- Auto mode (iMode=1):
  - Dwell counter counts 0..DWELL-1.
  - At DWELL-1: counter <= 0, ch <= (ch==CHANNELS-1) ? 0 : ch+1, oStep <= 1.
  - oErr=0; iSel is ignored.
- Mode transitions:
  - Manual->auto: scan starts from the current ch with the counter at 0, so the first advance comes DWELL cycles later.
  - Auto->manual: ch <= iSel (valid) at the next edge; the counter is cleared.
- Hold (iHold=1, iRST=0):
  - ch and the counter are frozen; oStep=0.
  - oZ is still refreshed from the held channel.
  - oErr is still evaluated in manual mode.
  - Hold overrides both mode actions.
- Wrap-around: CHANNELS-1 -> 0, also for non-power-of-2 CHANNELS (never visits indices >= CHANNELS).
- DWELL=1: channel advances every cycle and oStep stays high continuously.
- Simultaneous iMode change and iHold=1: hold wins, and the mode takes effect on the first cycle after hold drops.

Decomposition:
- Package selector_pkg:
  - mode constants MODE_MANUAL=1'b0, MODE_AUTO=1'b1;
  - a function for the ceil-log2 used to check SEL_W.
- One natural sub-module, scan_timer:
  - dwell counter with inputs clear, enable, hold;
  - output tick at terminal count.
- Top level holds the channel register, the mux and the output registers.

Test Plan:
- Defaults; data C0=0001, C1=0010, C2=0100, C3=1000; manual mode; iSel=0,1,2,3 at 10-cycle spacing -> oZ=0001,0010,0100,1000 one cycle after each change; oCh follows; oStep=0, oErr=0.
- Auto mode, DWELL=4, from reset -> oCh sequence 0,1,2,3,0 changing every 4 cycles; oStep pulses exactly on the cycle oCh changes; oZ=0001,0010,0100,1000,0001.
- Auto scan at ch=2; iHold=1 for 6 cycles; change C2 to 1111 during the hold -> oCh stays 2, oZ becomes 1111 one cycle later, no oStep; after release, ch=3 after the remaining dwell.
- CHANNELS=3, SEL_W=2, manual, iSel=3 after iSel=1 -> oCh stays 1, oErr=1; iSel=2 -> oCh=2, oErr=0; auto scan wraps 2->0.
- iRST=1 for one cycle mid-scan at ch=3, counter=2 -> next edge oZ=0, oCh=0, oStep=0; scan restarts and first advance occurs after 4 cycles.
- Auto->manual with iSel=2 while ch=0 -> oCh=2 next edge; back to auto -> first oStep after DWELL cycles.
